uart_tx_arbiter: RTL and testbench

//   Shares one uart_tx serializer between NUM_REQ byte-stream requesters.

---
 rtl/uart_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and limits for the UART transmit path.
// Holds the tx controller state enum and the busy-wait timeout.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_e;

  localparam int BUSY_TIMEOUT = 4;
  localparam int UART_DATA_W  = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick over a masked request set.
// Search starts at i_ptr and wraps; lowest index after the pointer wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic [N-1:0]  i_mask,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  logic [N-1:0] w_req;

  assign w_req = i_req & i_mask;

  // Scan from the pointer upward with wrap; first eligible request wins.
  always_comb begin : scan
    int j;
    o_grant = '0;
    o_idx   = '0;
    o_found = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (!o_found && w_req[j]) begin
        o_found    = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between NUM_REQ byte requesters.
// Optional UART_ARB_PACKET_LOCK_EN holds the grant until req_last.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = UART_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_start,
  input  logic                        tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        active
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(BUSY_TIMEOUT) + 1;

  tx_state_e         r_state;
  tx_state_e         w_next;
  logic [IDW-1:0]    r_rr_ptr;
  logic [IDW-1:0]    r_grant;
  logic [DATA_W-1:0] r_tx_data;
  logic [CW-1:0]     r_cnt;

  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDW-1:0]     w_idx;
  logic [IDW-1:0]     w_ptr_nxt;
  logic               w_found;
  logic               w_accept;
  logic [DATA_W-1:0]  w_byte;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .i_mask  (w_mask),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  // rst_n gates acceptance so req_ready is low while reset is held.
  assign w_accept = rst_n && (r_state == IDLE)
                  && !tx_busy && w_found;
  assign w_byte   = req_data[int'(w_idx)*DATA_W +: DATA_W];
  assign w_ptr_nxt = (w_idx == IDW'(NUM_REQ-1))
                   ? '0 : w_idx + IDW'(1);

`ifdef UART_ARB_PACKET_LOCK_EN
  logic r_lock;

  assign w_mask = r_lock ? (NUM_REQ'(1) << r_grant) : '1;

  // Hold the grant across a packet; the last byte releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_lock <= 1'b0;
    else if (w_accept) r_lock <= !req_last[w_idx];
  end
`else
  logic w_unused_last;

  assign w_mask        = '1;
  assign w_unused_last = ^req_last;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; WAIT_BUSY gives up after BUSY_TIMEOUT cycles.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (w_accept) w_next = LAUNCH;
      LAUNCH:    w_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)
          w_next = WAIT_DONE;
        else if (r_cnt == CW'(BUSY_TIMEOUT-1))
          w_next = IDLE;
      end
      WAIT_DONE: if (!tx_busy) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Outputs decoded from state; ready only in IDLE.
  always_comb begin
    tx_start  = 1'b0;
    active    = 1'b0;
    req_ready = '0;
    unique case (r_state)
      IDLE:    req_ready = w_accept ? w_grant : '0;
      LAUNCH:  begin
        tx_start = 1'b1;
        active   = 1'b1;
      end
      default: active = 1'b1;
    endcase
  end

  // Capture byte, grant and advance the pointer on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_data <= '0;
      r_grant   <= '0;
      r_rr_ptr  <= '0;
    end else if (w_accept) begin
      r_tx_data <= w_byte;
      r_grant   <= w_idx;
      r_rr_ptr  <= w_ptr_nxt;
    end
  end

  // Count cycles spent waiting for tx_busy to rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_cnt <= '0;
    else if (r_state == WAIT_BUSY) r_cnt <= r_cnt + CW'(1);
    else                           r_cnt <= '0;
  end

  assign tx_data  = r_tx_data;
  assign grant_id = r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random checks of uart_tx_arbiter.
// Reference model works from queues, a pointer and frame timing.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   tx_data;
  logic            tx_start;
  logic            tx_busy;
  logic [1:0]      grant_id;
  logic            active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active)
  );

  // uart_tx stand-in: busy 1 cycle after start, for 10 cycles.
  bit stuck = 1'b0;
  int busy_left = 0;
  always @(posedge clk) begin
    if (tx_start && !stuck) busy_left <= 10;
    else if (busy_left > 0) busy_left <= busy_left - 1;
  end
  assign tx_busy = (busy_left > 0);

  logic [8:0] q[N][$];
  int acc_log[$];
  int acc_cyc[$];

  int         cyc = 0;
  int         m_ptr = 0;
  int         m_gid = 0;
  bit         m_lock = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         m_start = -100;
  int         m_idle = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++)
      if (q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic step(input bit rnd);
    int win;
    int j;
    logic [N-1:0] exp_rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      bit v;
      v = (q[i].size() > 0) && (!rnd || ($urandom_range(0, 3) != 0));
      req_valid[i] = v;
      req_last[i]  = v ? q[i][0][8] : 1'($urandom_range(0, 1));
      req_data[i*DW +: DW] = v ? q[i][0][7:0] : 8'($urandom);
    end
    #1;
    win = -1;
    if (cyc >= m_idle && !tx_busy)
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (win < 0 && req_valid[j] && (!m_lock || j == m_gid))
          win = j;
      end
    exp_rdy = (win >= 0) ? (N'(1) << win) : '0;
    chk("req_ready", req_ready, exp_rdy);
    chk("tx_start", tx_start, (cyc == m_start));
    chk("active", active, (cyc >= m_start && cyc < m_idle));
    chk("tx_data", tx_data, m_data);
    chk("grant_id", grant_id, m_gid);
    for (int i = 0; i < N; i++)
      if (req_ready[i]) begin
        acc_log.push_back(i);
        acc_cyc.push_back(cyc);
      end
    if (win >= 0) begin
      m_data = q[win][0][7:0];
      m_gid  = win;
      m_ptr  = (win + 1) % N;
`ifdef UART_ARB_PACKET_LOCK_EN
      m_lock = !q[win][0][8];
`endif
      m_start = cyc + 1;
      m_idle  = cyc + (stuck ? 6 : 13);
      void'(q[win].pop_front());
    end
    cyc++;
  endtask

  task automatic drain(input int budget, input bit rnd);
    int n = 0;
    while ((pending() || cyc < m_idle || tx_busy) && n < budget) begin
      step(rnd);
      n++;
    end
    chk("drain_budget", (n < budget), 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_tx_start", tx_start, 0);
    chk("rst_active", active, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_grant_id", grant_id, 0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_ptr   = 0;
    m_lock  = 1'b0;
    m_gid   = 0;
    m_data  = 8'h00;
    m_start = -100;
    m_idle  = cyc;
  endtask

  initial begin
    int n;
    int total;
    int exp2[5];
    int exp5[5];
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    #1 rst_n = 1'b0;
    do_reset();

    // All requesters valid: order 0,1,2,3,0.
    acc_log.delete();
    for (int i = 0; i < N; i++)
      repeat (2) q[i].push_back({1'b1, 8'(8'h10 + i)});
    drain(300, 1'b0);
    exp2 = '{0, 1, 2, 3, 0};
    chk("t2_count", acc_log.size(), 8);
    for (int k = 0; k < 5; k++) chk("t2_order", acc_log[k], exp2[k]);

    // Single requester, back-to-back bytes spaced by a frame.
    acc_log.delete();
    acc_cyc.delete();
    q[0].push_back(9'h141);
    q[0].push_back(9'h142);
    drain(100, 1'b0);
    chk("t1_count", acc_log.size(), 2);
    chk("t1_spacing", acc_cyc[1] - acc_cyc[0], 13);

    // Stuck uart_tx: busy never rises, timeout back to IDLE.
    stuck = 1'b1;
    acc_log.delete();
    acc_cyc.delete();
    q[1].push_back(9'h1C1);
    q[1].push_back(9'h1C2);
    drain(100, 1'b0);
    stuck = 1'b0;
    chk("t3_count", acc_log.size(), 2);
    chk("t3_spacing", acc_cyc[1] - acc_cyc[0], 6);

    // Reset during WAIT_DONE, then first grant to requester 0.
    q[3].push_back(9'h1D3);
    n = 0;
    while (q[3].size() > 0 && n < 50) begin
      step(1'b0);
      n++;
    end
    chk("t4_accept", (n < 50), 1);
    repeat (4) step(1'b0);
    q[0].push_back(9'h1E0);
    q[2].push_back(9'h1E2);
    step(1'b0);
    do_reset();
    acc_log.delete();
    drain(100, 1'b0);
    chk("t4_count", acc_log.size(), 2);
    chk("t4_first", acc_log[0], 0);

    // Packet from requester 1 competing with requester 2.
    acc_log.delete();
    q[1].push_back(9'h0A0);
    q[1].push_back(9'h0A1);
    q[1].push_back(9'h1A2);
    q[2].push_back(9'h1B0);
    q[2].push_back(9'h1B1);
    drain(300, 1'b0);
`ifdef UART_ARB_PACKET_LOCK_EN
    exp5 = '{1, 1, 1, 2, 2};
`else
    exp5 = '{1, 2, 1, 2, 1};
`endif
    chk("t5_count", acc_log.size(), 5);
    for (int k = 0; k < 5; k++) chk("t5_order", acc_log[k], exp5[k]);

    // Pointer wrap after requester 3 wins from pointer 3.
    acc_log.delete();
    q[2].push_back(9'h1F2);
    drain(100, 1'b0);
    q[3].push_back(9'h1F3);
    drain(100, 1'b0);
    for (int i = 0; i < N; i++) q[i].push_back({1'b1, 8'(8'h60 + i)});
    drain(300, 1'b0);
    chk("t6_count", acc_log.size(), 6);
    chk("t6_r3", acc_log[1], 3);
    chk("t6_wrap", acc_log[2], 0);

    // Random packets with random valid gating.
    acc_log.delete();
    total = 0;
    for (int p = 0; p < 40; p++) begin
      int r;
      int len;
      r   = $urandom_range(0, N-1);
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) begin
        q[r].push_back({1'(b == len-1), 8'($urandom)});
        total++;
      end
    end
    drain(20000, 1'b1);
    chk("rand_count", acc_log.size(), total);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
